// File: rtl/hs_fifo.sv
// ---------------------------------------------------------------------------
// hs_fifo - multi-entry FIFO with four-phase handshakes on both sides.
//
// Words arrive from an upstream producer over a four-phase rr/ar handshake and
// are stored in a DEPTH-entry circular buffer. They are delivered in order to
// a downstream consumer over a four-phase rw/aw handshake. The input and
// output sides are independent FSMs and may overlap.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   din          write data, valid while rr=1
//   rr           upstream request (producer has a word)
//   ar           upstream acknowledge (word captured)
//   dout         read data, registered, stable while rw=1
//   rw           downstream request (word available)
//   aw           downstream acknowledge
//   full         occupancy == DEPTH
//   empty        occupancy == 0
//   level        (HS_FIFO_LEVEL_EN only) current occupancy, 0..DEPTH
//   almost_full  (HS_FIFO_LEVEL_EN only) occupancy >= DEPTH-1
//
// Optional feature macro: HS_FIFO_LEVEL_EN adds the level/almost_full ports.
// ---------------------------------------------------------------------------
module hs_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              rr,
  output logic              ar,
  output logic [DATA_W-1:0] dout,
  output logic              rw,
  input  logic              aw,
  output logic              full,
  output logic              empty
`ifdef HS_FIFO_LEVEL_EN
  ,
  output logic [CNT_W-1:0]  level,
  output logic              almost_full
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] L_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] L_CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] L_CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] L_PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] L_PTR_ONE  = PTR_W'(1);
`ifdef HS_FIFO_LEVEL_EN
  localparam logic [CNT_W-1:0] L_AF_LIMIT = CNT_W'(DEPTH - 1);
`endif

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_ACK  = 1'b1
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_REQ  = 2'b01,
    R_WAIT = 2'b10
  } rstate_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_dout;
  wstate_t           r_wstate;
  rstate_t           r_rstate;

  wstate_t           w_wstate_next;
  rstate_t           w_rstate_next;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_full;
  logic              w_empty;

  // Occupancy flags decode straight from the count register.
  assign w_full  = (r_count == L_DEPTH);
  assign w_empty = (r_count == L_CNT_ZERO);

  // Input side: capture din once per four-phase cycle, only while not full.
  // The full check uses the pre-edge count, so a same-edge pop never lets a
  // word in while the buffer is full.
  always_comb begin
    w_wstate_next = r_wstate;
    w_push        = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (rr && !w_full) begin
          w_push        = 1'b1;
          w_wstate_next = W_ACK;
        end else begin
          w_wstate_next = W_IDLE;
        end
      end
      W_ACK: begin
        if (!rr) begin
          w_wstate_next = W_IDLE;
        end else begin
          w_wstate_next = W_ACK;
        end
      end
      default: begin
        w_wstate_next = W_IDLE;
      end
    endcase
  end

  // Output side: load the head word, offer it, retire it on aw, then wait for
  // aw to drop. aw seen in any other state is ignored.
  always_comb begin
    w_rstate_next = r_rstate;
    w_load        = 1'b0;
    w_pop         = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (!w_empty) begin
          w_load        = 1'b1;
          w_rstate_next = R_REQ;
        end else begin
          w_rstate_next = R_IDLE;
        end
      end
      R_REQ: begin
        if (aw) begin
          w_pop         = 1'b1;
          w_rstate_next = R_WAIT;
        end else begin
          w_rstate_next = R_REQ;
        end
      end
      R_WAIT: begin
        if (!aw) begin
          w_rstate_next = R_IDLE;
        end else begin
          w_rstate_next = R_WAIT;
        end
      end
      default: begin
        w_rstate_next = R_IDLE;
      end
    endcase
  end

  // Occupancy update: push and pop on the same edge cancel out.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + L_CNT_ONE;
      2'b01:   w_count_next = r_count - L_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Control state, pointers, count and the output data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_wptr   <= L_PTR_ZERO;
      r_rptr   <= L_PTR_ZERO;
      r_count  <= L_CNT_ZERO;
      r_dout   <= {DATA_W{1'b0}};
    end else begin
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
      r_count  <= w_count_next;
      if (w_push) begin
        r_wptr <= r_wptr + L_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + L_PTR_ONE;
      end
      if (w_load) begin
        r_dout <= r_mem[r_rptr];
      end
    end
  end

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  assign ar    = (r_wstate == W_ACK);
  assign rw    = (r_rstate == R_REQ);
  assign dout  = r_dout;
  assign full  = w_full;
  assign empty = w_empty;

`ifdef HS_FIFO_LEVEL_EN
  assign level       = r_count;
  assign almost_full = (r_count >= L_AF_LIMIT);
`endif

endmodule

// File: tb/tb_hs_fifo.sv
// ---------------------------------------------------------------------------
// tb_hs_fifo - directed self-checking bench for hs_fifo (DATA_W=8, DEPTH=4).
// Build with HS_FIFO_LEVEL_EN defined to also check level/almost_full.
// ---------------------------------------------------------------------------
module tb_hs_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       rr;
  logic       ar;
  logic [7:0] dout;
  logic       rw;
  logic       aw;
  logic       full;
  logic       empty;
`ifdef HS_FIFO_LEVEL_EN
  logic [2:0] level;
  logic       almost_full;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  hs_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .rr    (rr),
    .ar    (ar),
    .dout  (dout),
    .rw    (rw),
    .aw    (aw),
    .full  (full),
    .empty (empty)
`ifdef HS_FIFO_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_level(input string tag, input logic [2:0] exp_lvl);
`ifdef HS_FIFO_LEVEL_EN
    check({tag, " level"}, {29'd0, level}, {29'd0, exp_lvl});
    check({tag, " almost_full"}, {31'd0, almost_full}, {31'd0, (exp_lvl >= 3'd3)});
`else
    check({tag, " empty"}, {31'd0, empty}, {31'd0, (exp_lvl == 3'd0)});
`endif
  endtask

  // One complete producer four-phase cycle with a bounded wait for ar.
  task automatic push_word(input logic [7:0] d, input string tag);
    int k;
    rr  = 1'b1;
    din = d;
    tick();
    k = 1;
    while (!ar && k < 20) begin
      tick();
      k++;
    end
    check({tag, " ar rise"}, {31'd0, ar}, 32'd1);
    rr = 1'b0;
    tick();
    check({tag, " ar fall"}, {31'd0, ar}, 32'd0);
  endtask

  // One complete consumer four-phase cycle with a bounded wait for rw.
  task automatic read_word(input logic [7:0] exp_d, input string tag);
    int k;
    k = 0;
    while (!rw && k < 20) begin
      tick();
      k++;
    end
    check({tag, " rw rise"}, {31'd0, rw}, 32'd1);
    check({tag, " dout"}, {24'd0, dout}, {24'd0, exp_d});
    aw = 1'b1;
    tick();
    check({tag, " rw fall"}, {31'd0, rw}, 32'd0);
    aw = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    rr    = 1'b0;
    aw    = 1'b0;
    din   = 8'h00;
    #1 reset = 1'b1;
    #1;
    check("rst ar",    {31'd0, ar},    32'd0);
    check("rst rw",    {31'd0, rw},    32'd0);
    check("rst full",  {31'd0, full},  32'd0);
    check("rst empty", {31'd0, empty}, 32'd1);
    check("rst dout",  {24'd0, dout},  32'd0);
    check_level("rst", 3'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1. single word, cycle-exact latency
    rr  = 1'b1;
    din = 8'hA5;
    tick();
    check("t1 ar", {31'd0, ar}, 32'd1);
    check("t1 rw early", {31'd0, rw}, 32'd0);
    rr = 1'b0;
    tick();
    check("t1 ar drop", {31'd0, ar}, 32'd0);
    check("t1 rw", {31'd0, rw}, 32'd1);
    check("t1 dout", {24'd0, dout}, 32'h0000_00A5);
    aw = 1'b1;
    tick();
    check("t1 rw drop", {31'd0, rw}, 32'd0);
    check("t1 empty", {31'd0, empty}, 32'd1);
    aw = 1'b0;
    tick();
    check("t1 idle rw", {31'd0, rw}, 32'd0);
    check("t1 dout hold", {24'd0, dout}, 32'h0000_00A5);

    // 2. fill, blocked push, one read releases a slot, drain
    push_word(8'h01, "t2 w01");
    push_word(8'h02, "t2 w02");
    push_word(8'h03, "t2 w03");
    check_level("t2 three", 3'd3);
    push_word(8'h04, "t2 w04");
    check("t2 full", {31'd0, full}, 32'd1);
    check_level("t2 four", 3'd4);
    rr  = 1'b1;
    din = 8'h05;
    tick();
    tick();
    check("t2 blocked ar", {31'd0, ar}, 32'd0);
    check("t2 head rw", {31'd0, rw}, 32'd1);
    check("t2 head dout", {24'd0, dout}, 32'h0000_0001);
    aw = 1'b1;
    tick();
    check("t2 pop edge ar", {31'd0, ar}, 32'd0);
    check("t2 pop edge full", {31'd0, full}, 32'd0);
    aw = 1'b0;
    tick();
    check("t2 late ar", {31'd0, ar}, 32'd1);
    check("t2 refull", {31'd0, full}, 32'd1);
    rr = 1'b0;
    tick();
    read_word(8'h02, "t2 r02");
    read_word(8'h03, "t2 r03");
    read_word(8'h04, "t2 r04");
    read_word(8'h05, "t2 r05");
    check("t2 drained", {31'd0, empty}, 32'd1);

    // 3. concurrent streaming, pointers wrap
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          push_word(8'(8'h10 + i), "t3 push");
        end
      end
      begin
        for (int j = 0; j < 10; j++) begin
          read_word(8'(8'h10 + j), "t3 read");
        end
      end
    join
    check("t3 empty", {31'd0, empty}, 32'd1);
    check("t3 full", {31'd0, full}, 32'd0);

    // 4. simultaneous push and pop at count=2
    push_word(8'h20, "t4 w20");
    push_word(8'h21, "t4 w21");
    check_level("t4 before", 3'd2);
    check("t4 head", {24'd0, dout}, 32'h0000_0020);
    rr  = 1'b1;
    din = 8'h22;
    aw  = 1'b1;
    tick();
    check("t4 ar", {31'd0, ar}, 32'd1);
    check("t4 rw", {31'd0, rw}, 32'd0);
    check_level("t4 same edge", 3'd2);
    rr = 1'b0;
    aw = 1'b0;
    tick();
    check_level("t4 after", 3'd2);
    read_word(8'h21, "t4 r21");
    check("t4 one left", {31'd0, empty}, 32'd0);
    read_word(8'h22, "t4 r22");
    check("t4 empty", {31'd0, empty}, 32'd1);

    // 5. asynchronous reset while offering a word with count=3
    push_word(8'h30, "t5 w30");
    push_word(8'h31, "t5 w31");
    push_word(8'h32, "t5 w32");
    check("t5 rw", {31'd0, rw}, 32'd1);
    check("t5 dout", {24'd0, dout}, 32'h0000_0030);
    #2 reset = 1'b1;
    #1;
    check("t5 rst rw", {31'd0, rw}, 32'd0);
    check("t5 rst ar", {31'd0, ar}, 32'd0);
    check("t5 rst empty", {31'd0, empty}, 32'd1);
    check("t5 rst dout", {24'd0, dout}, 32'd0);
    check_level("t5 rst", 3'd0);
    tick();
    reset = 1'b0;
    tick();
    push_word(8'h77, "t5 w77");
    read_word(8'h77, "t5 r77");
    check("t5 empty", {31'd0, empty}, 32'd1);

    // 6. aw pulse outside R_REQ on an empty FIFO is ignored
    aw = 1'b1;
    tick();
    tick();
    check("t6 rw", {31'd0, rw}, 32'd0);
    check("t6 empty", {31'd0, empty}, 32'd1);
    check_level("t6 pulse", 3'd0);
    aw = 1'b0;
    tick();
    check("t6 ar", {31'd0, ar}, 32'd0);
    push_word(8'h88, "t6 w88");
    read_word(8'h88, "t6 r88");
    check("t6 end empty", {31'd0, empty}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
